// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the round-robin GCD scheduler.
package gcd_pkg;

    localparam int GCD_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_e;

    function automatic int gcd_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gcd_rr_arb.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr wins.
module gcd_rr_arb
    import gcd_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = gcd_id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_id     = IW'(w_idx);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_rr_sched.sv
// Shares one iterative subtract/swap GCD datapath between N val/rdy requesters.
//   state   | meaning
//   ST_IDLE | offer round-robin grant, latch operands on handshake
//   ST_CALC | one Euclid step per cycle until B == 0
//   ST_DONE | present result + id until resp_rdy
module gcd_rr_sched
    import gcd_pkg::*;
#(
    parameter  int W  = GCD_W_DEFAULT,
    parameter  int N  = 4,
    localparam int IW = gcd_id_w(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_val,
    output logic [N-1:0]    req_rdy,
    input  logic [N*W-1:0]  req_a,
    input  logic [N*W-1:0]  req_b,
    output logic            resp_val,
    input  logic            resp_rdy,
    output logic [W-1:0]    resp_result,
    output logic [IW-1:0]   resp_id,
    output logic            busy
);

    gcd_state_e    r_state;
    gcd_state_e    w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [IW-1:0] r_id;

    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_gnt_id;
    logic          w_fire;
    logic [W-1:0]  w_sel_a;
    logic [W-1:0]  w_sel_b;

    gcd_rr_arb #(.N(N)) u_arb (
        .req    (req_val),
        .ptr    (r_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign w_sel_a   = req_a[int'(w_gnt_id)*W +: W];
    assign w_sel_b   = req_b[int'(w_gnt_id)*W +: W];
    assign w_ptr_nxt = (int'(w_gnt_id) == N - 1) ? '0 : w_gnt_id + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_rdy     = '0;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Grant is suppressed while reset is asserted so no handshake is seen.
                req_rdy = reset ? '0 : w_gnt;
                w_fire  = |w_gnt;
                if (w_fire) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if ((r_a >= r_b) && (r_b == '0)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_id  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                        r_id  <= w_gnt_id;
                        r_ptr <= w_ptr_nxt;
                    end
                end
                ST_CALC: begin
                    if (r_a < r_b) begin
                        r_a <= r_b;
                        r_b <= r_a;
                    end else if (r_b != '0) begin
                        r_a <= r_a - r_b;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_val    = (r_state == ST_DONE);
    assign resp_result = resp_val ? r_a  : '0;
    assign resp_id     = resp_val ? r_id : '0;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gcd_rr_sched.sv
// Self-checking bench for gcd_rr_sched: directed edge cases plus randomized round-robin stress.
module tb_gcd_rr_sched;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_val;
    logic [N-1:0]   req_rdy;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_val;
    logic           resp_rdy;
    logic [W-1:0]   resp_result;
    logic [IW-1:0]  resp_id;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;
    int glog[$];

    gcd_rr_sched #(.W(W), .N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_result (resp_result),
        .resp_id     (resp_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Modulo form of Euclid, deliberately unlike the subtract/swap datapath.
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] rv, input int p);
        for (int k = 0; k < N; k++) begin
            if (rv[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_op();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return '0;
        return W'($urandom_range(1, 63));
    endfunction

    // Single-requester job with resp_rdy held high; exp_lat = edges from acceptance to resp_val.
    task automatic run_job(input string tag, input int id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int exp_lat);
        int            cyc;
        logic [N-1:0]  onehot;
        logic [W-1:0]  exp_res;
        exp_res    = ref_gcd(a, b);
        onehot     = '0;
        onehot[id] = 1'b1;
        req_val    = onehot;
        set_op(id, a, b);
        resp_rdy   = 1'b1;
        #1;
        check({tag, "_grant"}, 32'(req_rdy), 32'(onehot));
        tick();
        req_val = '0;
        set_op(id, 16'hFFFF, 16'h1234);
        cyc = 0;
        while (!resp_val && cyc < 70000) begin
            tick();
            cyc++;
        end
        check({tag, "_resp_seen"}, 32'(resp_val), 32'd1);
        if (exp_lat >= 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_result"}, 32'(resp_result), 32'(exp_res));
        check({tag, "_id"}, 32'(resp_id), 32'(id));
        m_ptr = (id + 1) % N;
        tick();
        check({tag, "_back_idle"}, 32'(busy), 32'd0);
    endtask

    // Cycle-by-cycle scoreboard: one job outstanding, grants predicted from m_ptr.
    task automatic run_engine(input int njobs, input bit rnd, input int budget);
        int            done_jobs;
        int            cyc;
        int            g;
        bit            m_busy;
        bit            stalled;
        int            exp_id;
        logic [W-1:0]  exp_res;
        logic [W-1:0]  prev_res;
        logic [IW-1:0] prev_id;
        logic [N-1:0]  exp_rdy;
        logic [W-1:0]  fa[N];
        logic [W-1:0]  fb[N];
        fa = '{16'd12, 16'd35, 16'd9, 16'd40};
        fb = '{16'd18, 16'd14, 16'd0, 16'd64};
        done_jobs = 0;
        cyc       = 0;
        m_busy    = 1'b0;
        stalled   = 1'b0;
        exp_id    = 0;
        exp_res   = '0;
        prev_res  = '0;
        prev_id   = '0;
        while (done_jobs < njobs && cyc < budget) begin
            if (rnd) begin
                req_val  = N'($urandom);
                resp_rdy = 1'($urandom_range(0, 1));
                for (int i = 0; i < N; i++) set_op(i, rand_op(), rand_op());
            end else begin
                req_val  = '1;
                resp_rdy = 1'b1;
                for (int i = 0; i < N; i++) set_op(i, fa[i], fb[i]);
            end
            #1;
            exp_rdy = '0;
            g       = -1;
            if (!m_busy) begin
                g = rr_pick(req_val, m_ptr);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
            check("busy", 32'(busy), 32'(m_busy));
            if (stalled) begin
                check("stall_val", 32'(resp_val), 32'd1);
                check("stall_result", 32'(resp_result), 32'(prev_res));
                check("stall_id", 32'(resp_id), 32'(prev_id));
            end
            if (resp_val) begin
                if (!m_busy) begin
                    check("resp_spurious", 32'(resp_val), 32'd0);
                end else if (resp_rdy) begin
                    check("resp_id", 32'(resp_id), 32'(exp_id));
                    check("resp_result", 32'(resp_result), 32'(exp_res));
                    m_busy = 1'b0;
                    done_jobs++;
                end
            end
            stalled  = resp_val && !resp_rdy;
            prev_res = resp_result;
            prev_id  = resp_id;
            if (g >= 0) begin
                exp_id  = g;
                exp_res = ref_gcd(req_a[g*W +: W], req_b[g*W +: W]);
                m_busy  = 1'b1;
                m_ptr   = (g + 1) % N;
                glog.push_back(g);
            end
            tick();
            cyc++;
        end
        check("engine_jobs_done", 32'(done_jobs), 32'(njobs));
        req_val  = '0;
        resp_rdy = 1'b1;
        cyc = 0;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int order[5];
        order    = '{0, 1, 2, 3, 0};
        reset    = 1'b1;
        req_val  = '1;
        req_a    = '0;
        req_b    = '0;
        resp_rdy = 1'b0;

        tick();
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_resp_val", 32'(resp_val), 32'd0);
        check("rst_resp_result", 32'(resp_result), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset   = 1'b0;
        req_val = '0;
        m_ptr   = 0;

        run_job("j27_15", 0, 16'd27, 16'd15, 10);
        run_job("j5_0", 0, 16'd5, 16'd0, 1);
        run_job("j0_7", 0, 16'd0, 16'd7, 2);
        run_job("j0_0", 1, 16'd0, 16'd0, 1);
        run_job("jmax_1", 3, 16'd65535, 16'd1, 65537);

        // Stalled response: requester 3 waits behind a DONE held for 20 cycles.
        req_val = 4'b0010;
        set_op(1, 16'd12, 16'd8);
        set_op(3, 16'd9, 16'd6);
        resp_rdy = 1'b0;
        #1;
        check("hold_grant", 32'(req_rdy), 32'h2);
        tick();
        req_val = 4'b1000;
        cyc = 0;
        while (!resp_val && cyc < 200) begin
            tick();
            cyc++;
        end
        check("hold_resp_seen", 32'(resp_val), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_val", 32'(resp_val), 32'd1);
            check("hold_result", 32'(resp_result), 32'd4);
            check("hold_id", 32'(resp_id), 32'd1);
            check("hold_no_grant", 32'(req_rdy), 32'd0);
        end
        resp_rdy = 1'b1;
        #1;
        check("hs_cycle_no_grant", 32'(req_rdy), 32'd0);
        tick();
        resp_rdy = 1'b0;
        check("post_hs_resp_val", 32'(resp_val), 32'd0);
        check("post_hs_grant", 32'(req_rdy), 32'h8);
        tick();
        req_val  = '0;
        resp_rdy = 1'b1;
        cyc = 0;
        while (!resp_val && cyc < 200) begin
            tick();
            cyc++;
        end
        check("second_result", 32'(resp_result), 32'd3);
        check("second_id", 32'(resp_id), 32'd3);
        tick();
        m_ptr = 0;

        // Reset mid-CALC discards the job and returns ptr to 0.
        req_val = 4'b0001;
        set_op(0, 16'd27, 16'd15);
        #1;
        tick();
        req_val = '0;
        for (int i = 0; i < 4; i++) tick();
        check("midcalc_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        req_val = '1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_resp_val", 32'(resp_val), 32'd0);
        check("abort_ptr_zero", 32'(req_rdy), 32'h1);
        run_job("after_abort", 2, 16'd12, 16'd18, -1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_ptr = 0;
        glog.delete();
        run_engine(5, 1'b0, 500);
        for (int i = 0; i < 5; i++) begin
            if (i < glog.size()) check("rr_order", 32'(glog[i]), 32'(order[i]));
            else check("rr_order_missing", 32'(i), 32'(glog.size()));
        end

        run_engine(500, 1'b1, 30000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
